// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and execution-unit FSM encoding.
// The ALU control decoder imports this same package.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_MUL = 3'd5;

    typedef enum logic {
        StIdle = 1'b0,
        StMul  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_exec_if.sv
// Request/result bundle between the ID/EX stage logic and the EX execution unit.
interface alu_exec_if #(
    parameter int unsigned WIDTH = 32
);

    logic             start_i;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             done_o;
    logic             busy_o;

    // Pipeline side: issues requests, observes results and stall.
    modport master (
        output start_i, ALUCtrl_i, data1_i, data2_i,
        input  result_o, zero_o, done_o, busy_o
    );

    // Execution unit side.
    modport slave (
        input  start_i, ALUCtrl_i, data1_i, data2_i,
        output result_o, zero_o, done_o, busy_o
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// Only the low WIDTH product bits are produced; the high half of the shifted
// multiplicand can never reach them, so the registers keep just WIDTH bits.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] product_low_o,
    output logic             last_o
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Next-state: load operands on accept, otherwise one shift-add step when enabled.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
        end
    end

    // Datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Product after this cycle's step, so the final step's sum is captured directly.
    assign product_low_o = acc_d;
    assign last_o        = step_i && (cnt_q == CntLast);

endmodule

// File: rtl/alu_exec.sv
// EX-stage execution unit: single-cycle add/sub/and/or plus a 32-step iterative
// multiply that holds busy_o high so the pipeline stalls.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_exec_if.slave  bus
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic             mul_load;
    logic             mul_step;
    logic [WIDTH-1:0] mul_product;
    logic             mul_last;

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .load_i        (mul_load),
        .step_i        (mul_step),
        .a_i           (bus.data1_i),
        .b_i           (bus.data2_i),
        .product_low_o (mul_product),
        .last_o        (mul_last)
    );

    // FSM next-state, single-cycle datapath and result/flag next values.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        mul_load = 1'b0;
        mul_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    done_d = 1'b1;
                    case (bus.ALUCtrl_i)
                        ALU_ADD: result_d = bus.data1_i + bus.data2_i;
                        ALU_SUB: result_d = bus.data1_i - bus.data2_i;
                        ALU_AND: result_d = bus.data1_i & bus.data2_i;
                        ALU_OR:  result_d = bus.data1_i | bus.data2_i;
                        ALU_MUL: begin
                            done_d   = 1'b0;
                            mul_load = 1'b1;
                            state_d  = StMul;
                        end
                        default: result_d = '0;
                    endcase
                end
            end
            StMul: begin
                // Requests arriving here are dropped, not queued.
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d = mul_product;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Flag tracks exactly the value loaded into the result register.
        if (done_d) begin
            zero_d = (result_d == '0);
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
    assign bus.done_o   = done_q;
    assign bus.busy_o   = (state_q == StMul);

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec.
module tb_alu_exec;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    alu_exec_if #(.WIDTH(32)) bus ();

    alu_exec #(
        .WIDTH (32)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and land 1 ns after the rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle; returns in the cycle after acceptance.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i   = 1'b1;
        bus.ALUCtrl_i = op;
        bus.data1_i   = a;
        bus.data2_i   = b;
        next_cycle();
        bus.start_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.ALUCtrl_i = 3'd0;
        bus.data1_i = '0;
        bus.data2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.result_o !== 32'h0) begin
            n_bad++; $display("FAIL reset_result: got %h expected 00000000", bus.result_o);
        end
        n_cmp++;
        if (bus.zero_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_zero: got %b expected 1", bus.zero_o);
        end
        n_cmp++;
        if (bus.done_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done_o);
        end
        n_cmp++;
        if (bus.busy_o !== 1'b0) begin
            n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
        end
        #2 rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_add();
        issue(3'd1, 32'd5, 32'd7);
        n_cmp++;
        if (bus.done_o !== 1'b1) begin
            n_bad++; $display("FAIL add_done: got %b expected 1", bus.done_o);
        end
        n_cmp++;
        if (bus.result_o !== 32'd12) begin
            n_bad++; $display("FAIL add_result: got %h expected 0000000c", bus.result_o);
        end
        n_cmp++;
        if (bus.zero_o !== 1'b0) begin
            n_bad++; $display("FAIL add_zero: got %b expected 0", bus.zero_o);
        end
        n_cmp++;
        if (bus.busy_o !== 1'b0) begin
            n_bad++; $display("FAIL add_busy: got %b expected 0", bus.busy_o);
        end
        next_cycle();
        n_cmp++;
        if (bus.done_o !== 1'b0 || bus.result_o !== 32'd12) begin
            n_bad++; $display("FAIL add_hold: got done=%b res=%h expected done=0 res=0000000c",
                              bus.done_o, bus.result_o);
        end
    endtask

    task automatic test_back_to_back();
        bus.start_i   = 1'b1;
        bus.ALUCtrl_i = 3'd2;
        bus.data1_i   = 32'd3;
        bus.data2_i   = 32'd5;
        next_cycle();
        bus.data1_i   = 32'd9;
        bus.data2_i   = 32'd9;
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 32'hFFFF_FFFE || bus.zero_o !== 1'b0) begin
            n_bad++; $display("FAIL sub_neg: got done=%b res=%h z=%b expected done=1 res=fffffffe z=0",
                              bus.done_o, bus.result_o, bus.zero_o);
        end
        next_cycle();
        bus.start_i = 1'b0;
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 32'h0 || bus.zero_o !== 1'b1) begin
            n_bad++; $display("FAIL sub_zero: got done=%b res=%h z=%b expected done=1 res=00000000 z=1",
                              bus.done_o, bus.result_o, bus.zero_o);
        end
        next_cycle();
        n_cmp++;
        if (bus.done_o !== 1'b0) begin
            n_bad++; $display("FAIL sub_done_end: got %b expected 0", bus.done_o);
        end
    endtask

    task automatic test_mul();
        int busy_err;
        int done_err;
        busy_err = 0;
        done_err = 0;
        issue(3'd5, 32'h1234, 32'h10);
        // Cycles T+1 .. T+32; a stray add request is raised in cycle T+10.
        for (int k = 1; k <= 32; k++) begin
            if (bus.busy_o !== 1'b1) busy_err++;
            if (bus.done_o !== 1'b0) done_err++;
            if (k == 10) begin
                bus.start_i   = 1'b1;
                bus.ALUCtrl_i = 3'd1;
                bus.data1_i   = 32'd1;
                bus.data2_i   = 32'd1;
            end
            if (k == 11) bus.start_i = 1'b0;
            next_cycle();
        end
        n_cmp++;
        if (busy_err != 0 || done_err != 0) begin
            n_bad++; $display("FAIL mul_busy_window: got busy_err=%0d done_err=%0d expected 0 and 0",
                              busy_err, done_err);
        end
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            n_bad++; $display("FAIL mul_done: got done=%b busy=%b expected done=1 busy=0",
                              bus.done_o, bus.busy_o);
        end
        n_cmp++;
        if (bus.result_o !== 32'h0001_2340 || bus.zero_o !== 1'b0) begin
            n_bad++; $display("FAIL mul_result: got res=%h z=%b expected res=00012340 z=0",
                              bus.result_o, bus.zero_o);
        end
        next_cycle();
        n_cmp++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 32'h0001_2340) begin
            n_bad++; $display("FAIL mul_no_extra: got done=%b busy=%b res=%h expected 0 0 00012340",
                              bus.done_o, bus.busy_o, bus.result_o);
        end
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        bad = 0;
        issue(3'd5, 32'd3, 32'd4);
        repeat (14) next_cycle();
        // Now in cycle T+15; assert reset between edges.
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.result_o !== 32'h0 || bus.zero_o !== 1'b1 || bus.done_o !== 1'b0
            || bus.busy_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_mul: got res=%h z=%b d=%b b=%b expected 00000000 1 0 0",
                              bus.result_o, bus.zero_o, bus.done_o, bus.busy_o);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            next_cycle();
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL rst_no_done: got %0d bad cycles expected 0", bad);
        end
        issue(3'd1, 32'd1, 32'd1);
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 32'd2 || bus.zero_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_then_add: got d=%b res=%h z=%b expected 1 00000002 0",
                              bus.done_o, bus.result_o, bus.zero_o);
        end
    endtask

    task automatic test_mul_wrap();
        issue(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (32) next_cycle();
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 32'h0000_0001 || bus.zero_o !== 1'b0) begin
            n_bad++; $display("FAIL mul_neg1: got d=%b res=%h z=%b expected 1 00000001 0",
                              bus.done_o, bus.result_o, bus.zero_o);
        end
        issue(3'd5, 32'h0001_0000, 32'h0001_0000);
        repeat (32) next_cycle();
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 32'h0 || bus.zero_o !== 1'b1) begin
            n_bad++; $display("FAIL mul_overflow: got d=%b res=%h z=%b expected 1 00000000 1",
                              bus.done_o, bus.result_o, bus.zero_o);
        end
    endtask

    task automatic test_logic_and_invalid();
        issue(3'd3, 32'hF0F0_1234, 32'h0FF0_00FF);
        n_cmp++;
        if (bus.result_o !== 32'h00F0_0034 || bus.zero_o !== 1'b0) begin
            n_bad++; $display("FAIL and_op: got res=%h z=%b expected 00f00034 0",
                              bus.result_o, bus.zero_o);
        end
        issue(3'd0, 32'hFF, 32'h0);
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 32'h0 || bus.zero_o !== 1'b1) begin
            n_bad++; $display("FAIL invalid0: got d=%b res=%h z=%b expected 1 00000000 1",
                              bus.done_o, bus.result_o, bus.zero_o);
        end
        issue(3'd4, 32'hA000_0000, 32'h0000_0005);
        n_cmp++;
        if (bus.result_o !== 32'hA000_0005 || bus.zero_o !== 1'b0) begin
            n_bad++; $display("FAIL or_op: got res=%h z=%b expected a0000005 0",
                              bus.result_o, bus.zero_o);
        end
        issue(3'd7, 32'hFF, 32'hFF);
        n_cmp++;
        if (bus.done_o !== 1'b1 || bus.result_o !== 32'h0 || bus.zero_o !== 1'b1) begin
            n_bad++; $display("FAIL invalid7: got d=%b res=%h z=%b expected 1 00000000 1",
                              bus.done_o, bus.result_o, bus.zero_o);
        end
        next_cycle();
        n_cmp++;
        if (bus.done_o !== 1'b0) begin
            n_bad++; $display("FAIL invalid_pulse: got %b expected 0", bus.done_o);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_reset_mid_mul();
        test_mul_wrap();
        test_logic_and_invalid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
